pdu_uart_bridge: RTL and testbench

- Sits on the PDU end of the CPU MMIO byte channel and bridges it to a physical 8N1 UART line.
- CPU-to-host direction: accepts the one-cycle `cpu_uart_data_valid`/`cpu_uart_data` pulses, buffers them in a small FIFO and serializes them on `uart_tx`.
- Host-to-CPU direction: deserializes `uart_rx` bytes, then drives the `pdu_uart_data_ready` / `pdu_uart_data` / `pdu_uart_data_accept` handoff toward the MMIO block.

---
 rtl/pdu_uart_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_pdu_uart_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdu_uart_bridge.sv
// PDU-side bridge between the CPU MMIO byte channel and an 8N1 UART line.
// TX bytes queue in a small FIFO (full => byte dropped, sticky flag); RX bytes hand off via ready/accept.

module pdu_uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   output logic [W-1:0] pop_dat_o,
   output logic         empty_o,
   output logic         full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop    = pop_i && !empty_o;
   // A pop in the same cycle frees a slot, so a push while full still lands.
   assign do_push   = push_i && (!full_o || do_pop);
   assign pop_dat_o = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end
endmodule

module pdu_uart_bridge #(
   parameter int CLK_DIV       = 868,
   parameter int TX_FIFO_DEPTH = 4,
   parameter int READY_HOLD    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_uart_data_valid,
   input  logic [7:0] cpu_uart_data,
   output logic       pdu_uart_data_ready,
   output logic [7:0] pdu_uart_data,
   input  logic       pdu_uart_data_accept,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic       tx_overflow,
   output logic       rx_error
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int HW = $clog2(READY_HOLD + 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(READY_HOLD - 1);

   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {H_IDLE, H_READY, H_WAIT_ACC} ho_state_t;

   tx_state_t     tx_state_q;
   logic [CW-1:0] tx_cnt_q;
   logic [2:0]    tx_bit_q;
   logic [7:0]    tx_sh_q;
   logic          tx_q, tx_ovf_q, tx_bit_end;
   logic          fifo_pop, fifo_empty, fifo_full;
   logic [7:0]    fifo_dat;

   rx_state_t     rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_sh_q;
   logic          rx_s1_q, rx_s2_q, rx_done_q, rx_ferr_q;

   ho_state_t     ho_state_q;
   logic [HW-1:0] ho_cnt_q;
   logic [7:0]    ho_dat_q;
   logic          ho_rdy_q, rx_err_q;

   assign tx_bit_end = (tx_cnt_q == DIV_LAST);
   // Load the shifter straight from idle, or from the last stop cycle so frames run back-to-back.
   assign fifo_pop   = !fifo_empty && (tx_state_q == T_IDLE || (tx_state_q == T_STOP && tx_bit_end));

   pdu_uart_fifo #(.W(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (cpu_uart_data_valid),
      .push_dat_i (cpu_uart_data),
      .pop_i      (fifo_pop),
      .pop_dat_o  (fifo_dat),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= T_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_q       <= 1'b1;
         tx_ovf_q   <= 1'b0;
      end else begin
         if (cpu_uart_data_valid && fifo_full && !fifo_pop) tx_ovf_q <= 1'b1;
         if (fifo_pop) begin
            tx_state_q <= T_START;
            tx_sh_q    <= fifo_dat;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
         end else begin
            case (tx_state_q)
               T_START: if (tx_bit_end) begin
                  tx_state_q <= T_DATA;
                  tx_q       <= tx_sh_q[0];
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
               end else tx_cnt_q <= tx_cnt_q + CW'(1);
               T_DATA: if (tx_bit_end) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_q <= T_STOP;
                     tx_q       <= 1'b1;
                  end else begin
                     tx_bit_q <= tx_bit_q + 3'd1;
                     tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                     tx_q     <= tx_sh_q[1];
                  end
               end else tx_cnt_q <= tx_cnt_q + CW'(1);
               T_STOP: if (tx_bit_end) begin
                  tx_state_q <= T_IDLE;
                  tx_cnt_q   <= '0;
               end else tx_cnt_q <= tx_cnt_q + CW'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= R_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_done_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1_q   <= uart_rx;
         rx_s2_q   <= rx_s1_q;
         rx_done_q <= 1'b0;
         rx_ferr_q <= 1'b0;
         case (rx_state_q)
            R_IDLE: if (!rx_s2_q) begin
               rx_state_q <= R_START;
               rx_cnt_q   <= '0;
            end
            // Half-bit re-check filters glitches and aligns later samples to bit centres.
            R_START: if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_q   <= '0;
               rx_bit_q   <= '0;
               rx_state_q <= rx_s2_q ? R_IDLE : R_DATA;
            end else rx_cnt_q <= rx_cnt_q + CW'(1);
            R_DATA: if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_q <= '0;
               rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
               else                  rx_bit_q   <= rx_bit_q + 3'd1;
            end else rx_cnt_q <= rx_cnt_q + CW'(1);
            R_STOP: if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_q   <= '0;
               rx_state_q <= R_IDLE;
               if (rx_s2_q) rx_done_q <= 1'b1;
               else         rx_ferr_q <= 1'b1;
            end else rx_cnt_q <= rx_cnt_q + CW'(1);
            default: rx_state_q <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ho_state_q <= H_IDLE;
         ho_cnt_q   <= '0;
         ho_dat_q   <= '0;
         ho_rdy_q   <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         if (rx_ferr_q || (rx_done_q && ho_state_q != H_IDLE)) rx_err_q <= 1'b1;
         case (ho_state_q)
            H_IDLE: if (rx_done_q) begin
               ho_dat_q   <= rx_sh_q;
               ho_rdy_q   <= 1'b1;
               ho_cnt_q   <= '0;
               ho_state_q <= H_READY;
            end
            H_READY: if (ho_cnt_q == HOLD_LAST) begin
               ho_rdy_q   <= 1'b0;
               ho_state_q <= H_WAIT_ACC;
            end else ho_cnt_q <= ho_cnt_q + HW'(1);
            H_WAIT_ACC: if (pdu_uart_data_accept) ho_state_q <= H_IDLE;
            default: ho_state_q <= H_IDLE;
         endcase
      end
   end

   assign uart_tx             = tx_q;
   assign tx_overflow         = tx_ovf_q;
   assign pdu_uart_data_ready = ho_rdy_q;
   assign pdu_uart_data       = ho_dat_q;
   assign rx_error            = rx_err_q;
endmodule

// File: tb/tb_pdu_uart_bridge.sv
// Scoreboard bench: stimulus pushes expected bytes, independent line/handoff monitors pop and compare.
module tb_pdu_uart_bridge;
   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
   localparam int HOLD    = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_uart_data_valid = 1'b0;
   logic [7:0] cpu_uart_data = 8'h00;
   logic       pdu_uart_data_ready;
   logic [7:0] pdu_uart_data;
   logic       pdu_uart_data_accept = 1'b0;
   logic       uart_rx = 1'b1;
   logic       uart_tx;
   logic       tx_overflow;
   logic       rx_error;

   always #5 clk = ~clk;

   pdu_uart_bridge #(.CLK_DIV(CLK_DIV), .TX_FIFO_DEPTH(DEPTH), .READY_HOLD(HOLD)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .cpu_uart_data_valid  (cpu_uart_data_valid),
      .cpu_uart_data        (cpu_uart_data),
      .pdu_uart_data_ready  (pdu_uart_data_ready),
      .pdu_uart_data        (pdu_uart_data),
      .pdu_uart_data_accept (pdu_uart_data_accept),
      .uart_rx              (uart_rx),
      .uart_tx              (uart_tx),
      .tx_overflow          (tx_overflow),
      .rx_error             (rx_error)
   );

   int         passed = 0;
   int         total  = 0;
   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   logic       rx_busy  = 1'b0;
   logic       err_exp  = 1'b0;
   logic       rx_abort = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] b, input logic expect_sent);
      if (expect_sent) tx_exp.push_back(b);
      cpu_uart_data_valid = 1'b1;
      cpu_uart_data       = b;
      tick();
      cpu_uart_data_valid = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit, output logic done);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         uart_rx = bits[i];
         for (int s = 0; s < CLK_DIV; s++) begin
            tick();
            if (rx_abort) begin
               uart_rx = 1'b1;
               return;
            end
         end
      end
      uart_rx = 1'b1;
      done = 1'b1;
   endtask

   // Reference model: a good frame is delivered only if the previous one was accepted;
   // a bad stop bit or an unaccepted predecessor makes the sticky error expected.
   task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
      logic done;
      send_rx(b, stop_bit, done);
      if (done) begin
         if (!stop_bit)    err_exp = 1'b1;
         else if (rx_busy) err_exp = 1'b1;
         else begin
            rx_exp.push_back(b);
            rx_busy = 1'b1;
         end
         repeat (8) tick();
      end
   endtask

   task automatic rx_accept();
      pdu_uart_data_accept = 1'b1;
      tick();
      pdu_uart_data_accept = 1'b0;
      rx_busy = 1'b0;
      tick();
   endtask

   task automatic wait_tx_idle();
      int n;
      n = 0;
      while (tx_exp.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("tx_drain", 32'(tx_exp.size()), 32'd0);
      repeat (2) tick();
   endtask

   task automatic tx_frame(output logic gap);
      logic       ok;
      logic [7:0] b;
      ok  = 1'b1;
      b   = 8'h00;
      gap = 1'b0;
      for (int i = 1; i < CLK_DIV; i++) begin
         @(negedge clk);
         if (rst) return;
         if (uart_tx !== 1'b0) ok = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
         for (int s = 0; s < CLK_DIV; s++) begin
            @(negedge clk);
            if (rst) return;
            if (s == 0) b[k] = uart_tx;
            else if (uart_tx !== b[k]) ok = 1'b0;
         end
      end
      for (int s = 0; s < CLK_DIV; s++) begin
         @(negedge clk);
         if (rst) return;
         if (uart_tx !== 1'b1) ok = 1'b0;
      end
      check("tx_frame_shape", 32'(ok), 32'd1);
      check("tx_frame_expected", 32'(tx_exp.size() != 0), 32'd1);
      if (tx_exp.size() != 0) check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
      gap = (tx_exp.size() != 0);
   endtask

   initial begin : tx_monitor
      logic gap_chk;
      gap_chk = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            gap_chk = 1'b0;
         end else if (gap_chk) begin
            gap_chk = 1'b0;
            check("tx_back_to_back", 32'(uart_tx), 32'd0);
            if (uart_tx === 1'b0) tx_frame(gap_chk);
         end else if (uart_tx === 1'b0) begin
            tx_frame(gap_chk);
         end
      end
   end

   initial begin : rx_monitor
      logic prev;
      int   hi;
      prev = 1'b0;
      hi   = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
            hi   = 0;
         end else begin
            if (pdu_uart_data_ready && !prev) begin
               check("rx_ready_expected", 32'(rx_exp.size() != 0), 32'd1);
               if (rx_exp.size() != 0) check("rx_data", 32'(pdu_uart_data), 32'(rx_exp.pop_front()));
               hi = 1;
            end else if (pdu_uart_data_ready) begin
               hi++;
            end else if (prev) begin
               check("rx_ready_len", hi, HOLD);
            end
            prev = pdu_uart_data_ready;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("%0d/%0d checks passed", passed, total);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic       l0, l1, l2;
      int         n_tx, lows;
      logic [7:0] rxb;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_ready", 32'(pdu_uart_data_ready), 32'd0);
      check("rst_data", 32'(pdu_uart_data), 32'd0);
      check("rst_tx_overflow", 32'(tx_overflow), 32'd0);
      check("rst_rx_error", 32'(rx_error), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      tx_exp.push_back(8'hA5);
      cpu_uart_data_valid = 1'b1;
      cpu_uart_data       = 8'hA5;
      @(negedge clk) l0 = uart_tx;
      tick();
      cpu_uart_data_valid = 1'b0;
      @(negedge clk) l1 = uart_tx;
      @(negedge clk) l2 = uart_tx;
      check("tx_start_latency", 32'({l0, l1, l2}), 32'h6);
      wait_tx_idle();
      check("tx_overflow_single", 32'(tx_overflow), 32'd0);

      for (int r = 0; r < 5; r++) begin
         n_tx = $urandom_range(1, 5);
         rxb  = 8'($urandom);
         fork
            begin
               for (int j = 0; j < n_tx; j++) push_tx(8'($urandom), 1'b1);
            end
            begin
               rx_frame(rxb, 1'b1);
            end
         join
         wait_tx_idle();
         rx_accept();
      end
      check("tx_overflow_random", 32'(tx_overflow), 32'd0);
      check("rx_error_random", 32'(rx_error), 32'(err_exp));

      for (int v = 1; v <= 6; v++) push_tx(8'(v), v <= 5);
      tick();
      check("tx_overflow_set", 32'(tx_overflow), 32'd1);
      wait_tx_idle();

      rx_frame(8'h3C, 1'b1);
      repeat (20) tick();
      check("rx_hold_data", 32'(pdu_uart_data), 32'h3C);
      check("rx_ready_low_waiting", 32'(pdu_uart_data_ready), 32'd0);
      rx_accept();
      rx_frame(8'($urandom), 1'b1);
      rx_accept();
      uart_rx = 1'b0;
      tick();
      uart_rx = 1'b1;
      repeat (20) tick();
      check("rx_error_glitch", 32'(rx_error), 32'(err_exp));

      rx_frame(8'h3C, 1'b1);
      rx_frame(8'h77, 1'b1);
      check("rx_error_overrun", 32'(rx_error), 32'(err_exp));
      check("rx_data_overrun", 32'(pdu_uart_data), 32'h3C);
      rx_accept();

      fork
         begin
            push_tx(8'h5A, 1'b1);
         end
         begin
            rx_frame(8'hA6, 1'b1);
         end
         begin
            repeat (15) tick();
            rx_abort = 1'b1;
            tick();
            rst = 1'b1;
            tx_exp.delete();
            rx_exp.delete();
            rx_busy = 1'b0;
            err_exp = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("midrst_uart_tx", 32'(uart_tx), 32'd1);
            check("midrst_ready", 32'(pdu_uart_data_ready), 32'd0);
            check("midrst_data", 32'(pdu_uart_data), 32'd0);
            check("midrst_tx_overflow", 32'(tx_overflow), 32'd0);
            check("midrst_rx_error", 32'(rx_error), 32'd0);
            tick();
            rst = 1'b0;
            rx_abort = 1'b0;
         end
      join
      lows = 0;
      repeat (12) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      check("tx_idle_after_reset", lows, 0);
      tick();

      fork
         push_tx(8'h81, 1'b1);
         rx_frame(8'h81, 1'b1);
      join
      wait_tx_idle();
      rx_accept();
      check("post_rst_tx_overflow", 32'(tx_overflow), 32'd0);
      check("post_rst_rx_error", 32'(rx_error), 32'(err_exp));

      rx_frame(8'h55, 1'b0);
      repeat (10) tick();
      check("rx_error_framing", 32'(rx_error), 32'(err_exp));
      check("rx_data_framing", 32'(pdu_uart_data), 32'h81);
      check("rx_all_delivered", 32'(rx_exp.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
